// File: rtl/fc_mem_pkg.sv
// Shared types for the weight/bias memory read-port arbiter.
// Latency: none (types and constants only).
// Backpressure: none.
package fc_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  // Requester indices; also the encoding of the owner and last-served flags.
  localparam logic REQ_CNN = 1'b0;
  localparam logic REQ_FC  = 1'b1;

endpackage

// File: rtl/fc_mem_arbiter_if.sv
// Requester, memory and status signals of the weight/bias read-port arbiter.
// Latency: none (wiring only).
// Backpressure: none; requesters hold req/addr/count until granted.
interface fc_mem_arbiter_if #(
  parameter int WORD_SIZE         = 16,
  parameter int MEM_ADDRESS_WIDTH = 10,
  parameter int COUNT_WIDTH       = 7
);

  logic                         req0;
  logic                         req1;
  logic [MEM_ADDRESS_WIDTH-1:0] addr0;
  logic [MEM_ADDRESS_WIDTH-1:0] addr1;
  logic [COUNT_WIDTH-1:0]       count0;
  logic [COUNT_WIDTH-1:0]       count1;
  logic                         grant0;
  logic                         grant1;
  logic                         valid0;
  logic                         valid1;
  logic                         done0;
  logic                         done1;
  logic [WORD_SIZE-1:0]         rd_data;
  logic [MEM_ADDRESS_WIDTH-1:0] mem_addr;
  logic                         mem_en;
  logic [WORD_SIZE-1:0]         mem_data;
  logic                         busy;

  // Arbiter side.
  modport slave (
    input  req0, req1, addr0, addr1, count0, count1, mem_data,
    output grant0, grant1, valid0, valid1, done0, done1, rd_data,
           mem_addr, mem_en, busy
  );

  // Requesters plus memory side.
  modport master (
    output req0, req1, addr0, addr1, count0, count1, mem_data,
    input  grant0, grant1, valid0, valid1, done0, done1, rd_data,
           mem_addr, mem_en, busy
  );

endinterface

// File: rtl/fc_mem_arbiter_rr_pick2.sv
// Two-way round-robin picker: on a tie, selects the requester not served last.
// Latency: combinational.
// Backpressure: none.
module rr_pick2
  import fc_mem_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic any,
  output logic sel
);

  // Single request wins outright; a tie goes to the requester not served last.
  always_comb begin
    any = req0 | req1;
    sel = REQ_CNN;
    if (req0 && req1) begin
      sel = (last == REQ_FC) ? REQ_CNN : REQ_FC;
    end else if (req1) begin
      sel = REQ_FC;
    end
  end

endmodule

// File: rtl/fc_mem_arbiter.sv
// Burst-read arbiter sharing one memory read port between CNN loader and FC DMA.
// Latency: grant one edge after request sample, first word one cycle after grant.
// Backpressure: none downstream; a burst occupies N+2 cycles, others wait in req.
module fc_mem_arbiter
  import fc_mem_pkg::*;
#(
  parameter int WORD_SIZE         = 16,
  parameter int MEM_ADDRESS_WIDTH = 10,
  parameter int COUNT_WIDTH       = 7
) (
  input  logic              clk,
  input  logic              rst,
  fc_mem_arbiter_if.slave   bus
);

  arb_state_t                   state_q;
  arb_state_t                   state_d;
  logic                         take;
  logic                         pick_any;
  logic                         pick_sel;
  logic                         last_q;
  logic                         owner_q;
  logic                         grant_q;
  logic                         valid_q;
  logic [MEM_ADDRESS_WIDTH-1:0] addr_q;
  logic [COUNT_WIDTH-1:0]       remain_q;
  logic [MEM_ADDRESS_WIDTH-1:0] req_addr;
  logic [COUNT_WIDTH-1:0]       req_count;

  rr_pick2 u_pick (
    .req0 (bus.req0),
    .req1 (bus.req1),
    .last (last_q),
    .any  (pick_any),
    .sel  (pick_sel)
  );

  // Burst parameters of whichever requester the picker selects.
  always_comb begin
    req_addr  = (pick_sel == REQ_FC) ? bus.addr1  : bus.addr0;
    req_count = (pick_sel == REQ_FC) ? bus.count1 : bus.count0;
  end

  // Next-state logic; a zero-length burst skips BURST so grant and done coincide.
  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          take    = 1'b1;
          state_d = (req_count == '0) ? DRAIN : BURST;
        end
      end
      BURST: begin
        if (remain_q == COUNT_WIDTH'(1)) begin
          state_d = DRAIN;
        end
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Burst bookkeeping: latch on grant, then walk address and remaining count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q   <= REQ_FC;
      owner_q  <= REQ_CNN;
      addr_q   <= '0;
      remain_q <= '0;
    end else if (take) begin
      last_q   <= pick_sel;
      owner_q  <= pick_sel;
      addr_q   <= req_addr;
      remain_q <= req_count;
    end else if (state_q == BURST && state_d == BURST) begin
      addr_q   <= addr_q + MEM_ADDRESS_WIDTH'(1);
      remain_q <= remain_q - COUNT_WIDTH'(1);
    end
  end

  // Grant pulse and word-valid track the one-cycle memory read latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      grant_q <= take;
      valid_q <= (state_q == BURST);
    end
  end

  // Steer status to the owner only; the memory port follows the burst state.
  always_comb begin
    bus.grant0   = grant_q && (owner_q == REQ_CNN);
    bus.grant1   = grant_q && (owner_q == REQ_FC);
    bus.valid0   = valid_q && (owner_q == REQ_CNN);
    bus.valid1   = valid_q && (owner_q == REQ_FC);
    bus.done0    = (state_q == DRAIN) && (owner_q == REQ_CNN);
    bus.done1    = (state_q == DRAIN) && (owner_q == REQ_FC);
    bus.rd_data  = bus.mem_data;
    bus.mem_addr = addr_q;
    bus.mem_en   = (state_q == BURST);
    bus.busy     = (state_q != IDLE);
  end

endmodule
